// File: rtl/exec_pkg.sv
// Shared opcode, funct and memory-tap constants for the execute stage.
package exec_pkg;

  // Major opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_LUI   = 6'd3;
  localparam logic [5:0] OP_ANDI  = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd5;
  localparam logic [5:0] OP_XORI  = 6'd6;
  localparam logic [5:0] OP_LW    = 6'd16;
  localparam logic [5:0] OP_LH    = 6'd18;
  localparam logic [5:0] OP_LB    = 6'd20;
  localparam logic [5:0] OP_SW    = 6'd24;
  localparam logic [5:0] OP_SH    = 6'd26;
  localparam logic [5:0] OP_SB    = 6'd28;
  localparam logic [5:0] OP_JAL   = 6'd41;

  // R-type funct codes
  localparam logic [4:0] FN_ADD = 5'd0;
  localparam logic [4:0] FN_SUB = 5'd2;
  localparam logic [4:0] FN_AND = 5'd8;
  localparam logic [4:0] FN_OR  = 5'd9;
  localparam logic [4:0] FN_XOR = 5'd10;
  localparam logic [4:0] FN_NOR = 5'd11;
  localparam logic [4:0] FN_SLL = 5'd16;
  localparam logic [4:0] FN_SRL = 5'd17;
  localparam logic [4:0] FN_SRA = 5'd18;

  // Link register written by jal
  localparam logic [4:0] REG_LINK = 5'd31;

  // Word indices of the three observed data words (byte address / 4)
  localparam logic [7:0] DM_IDX_532 = 8'd133;
  localparam logic [7:0] DM_IDX_576 = 8'd144;
  localparam logic [7:0] DM_IDX_900 = 8'd225;

endpackage

// File: rtl/exec_byte_ram.sv
// One byte lane of data memory: 256 x 8, synchronous write, asynchronous
// read on the access port plus three fixed-address observation taps.
module exec_byte_ram (
  input  logic       sysclk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] tap0_addr,
  input  logic [7:0] tap1_addr,
  input  logic [7:0] tap2_addr,
  output logic [7:0] tap0_data,
  output logic [7:0] tap1_data,
  output logic [7:0] tap2_data
);

  logic [7:0] mem_r [256];

  // Byte write on the rising edge; contents are never reset
  always_ff @(posedge sysclk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata     = mem_r[addr];
  assign tap0_data = mem_r[tap0_addr];
  assign tap1_data = mem_r[tap1_addr];
  assign tap2_data = mem_r[tap2_addr];

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, store lane enables, byte-lane data memory and the
// registered write-back boundary (op_w / wreg_w / result_w).
module exec_stage
  import exec_pkg::*;
(
  input  logic        sysclk,
  input  logic        cpu_resetn,
  input  logic [31:0] pc,
  input  logic [5:0]  op,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [10:0] aux,
  input  logic [31:0] os,
  input  logic [31:0] ot,
  input  logic [31:0] imm_dpl,
  output logic [4:0]  wreg_e,
  output logic [3:0]  wren_e,
  output logic [31:0] alu_result_e,
  output logic [4:0]  wreg_w,
  output logic [31:0] result_w,
  output logic [5:0]  op_w,
  output logic [31:0] dm532,
  output logic [31:0] dm576,
  output logic [31:0] dm900
);

  logic [4:0]  funct_s;
  logic [4:0]  shamt_s;
  logic [31:0] zimm_s;
  logic [31:0] addr_sum_s;
  logic [7:0]  word_idx_s;
  logic [31:0] rdata_s;
  logic [31:0] wb_data_s;
  logic [3:0]  lane_we_s;
  logic        unused_s;

  assign funct_s    = aux[4:0];
  assign shamt_s    = aux[10:6];
  assign zimm_s     = {16'h0000, imm_dpl[15:0]};
  assign addr_sum_s = os + imm_dpl;
  // Only bits [9:2] select the word; higher address bits alias
  assign word_idx_s = addr_sum_s[9:2];
  // Writes are held off while the core is in reset
  assign lane_we_s  = wren_e & {4{cpu_resetn}};
  assign unused_s   = ^{aux[5], addr_sum_s[31:10], addr_sum_s[1:0]};

  // ALU / store-data / link-address selection
  always_comb begin
    alu_result_e = 32'h0000_0000;
    case (op)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  alu_result_e = os + ot;
          FN_SUB:  alu_result_e = os - ot;
          FN_AND:  alu_result_e = os & ot;
          FN_OR:   alu_result_e = os | ot;
          FN_XOR:  alu_result_e = os ^ ot;
          FN_NOR:  alu_result_e = ~(os | ot);
          FN_SLL:  alu_result_e = ot << shamt_s;
          FN_SRL:  alu_result_e = ot >> shamt_s;
          FN_SRA:  alu_result_e = $unsigned($signed(ot) >>> shamt_s);
          default: alu_result_e = 32'h0000_0000;
        endcase
      end
      OP_ADDI: alu_result_e = os + imm_dpl;
      OP_LUI:  alu_result_e = {imm_dpl[15:0], 16'h0000};
      OP_ANDI: alu_result_e = os & zimm_s;
      OP_ORI:  alu_result_e = os | zimm_s;
      OP_XORI: alu_result_e = os ^ zimm_s;
      OP_SW, OP_SH, OP_SB: alu_result_e = ot;
      OP_JAL:  alu_result_e = pc + 32'd1;
      default: alu_result_e = 32'h0000_0000;
    endcase
  end

  // Destination register and byte-lane write enables
  always_comb begin
    wreg_e = 5'd0;
    wren_e = 4'b0000;
    case (op)
      OP_RTYPE: wreg_e = rd;
      OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_LH, OP_LB: wreg_e = rt;
      OP_JAL:  wreg_e = REG_LINK;
      OP_SW:   wren_e = 4'b1111;
      OP_SH:   wren_e = 4'b0011;
      OP_SB:   wren_e = 4'b0001;
      default: begin
        wreg_e = 5'd0;
        wren_e = 4'b0000;
      end
    endcase
  end

  // Four byte lanes of data memory
  for (genvar i = 0; i < 4; i++) begin : g_lane
    exec_byte_ram u_lane (
      .sysclk    (sysclk),
      .we        (lane_we_s[i]),
      .addr      (word_idx_s),
      .wdata     (alu_result_e[8*i +: 8]),
      .rdata     (rdata_s[8*i +: 8]),
      .tap0_addr (DM_IDX_532),
      .tap1_addr (DM_IDX_576),
      .tap2_addr (DM_IDX_900),
      .tap0_data (dm532[8*i +: 8]),
      .tap1_data (dm576[8*i +: 8]),
      .tap2_data (dm900[8*i +: 8])
    );
  end

  // Write-back value: load data (sign-extended for lh/lb) or ALU result
  always_comb begin
    wb_data_s = alu_result_e;
    case (op)
      OP_LW:   wb_data_s = rdata_s;
      OP_LH:   wb_data_s = {{16{rdata_s[15]}}, rdata_s[15:0]};
      OP_LB:   wb_data_s = {{24{rdata_s[7]}}, rdata_s[7:0]};
      default: wb_data_s = alu_result_e;
    endcase
  end

  // Write-back pipeline register, cleared asynchronously by reset
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      op_w     <= 6'd0;
      wreg_w   <= 5'd0;
      result_w <= 32'h0000_0000;
    end else begin
      op_w     <= op;
      wreg_w   <= wreg_e;
      result_w <= wb_data_s;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage.
module tb_exec_stage;

  logic        sysclk;
  logic        cpu_resetn;
  logic [31:0] pc;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [10:0] aux;
  logic [31:0] os;
  logic [31:0] ot;
  logic [31:0] imm_dpl;
  logic [4:0]  wreg_e;
  logic [3:0]  wren_e;
  logic [31:0] alu_result_e;
  logic [4:0]  wreg_w;
  logic [31:0] result_w;
  logic [5:0]  op_w;
  logic [31:0] dm532;
  logic [31:0] dm576;
  logic [31:0] dm900;

  int checks;
  int errors;

  exec_stage dut (
    .sysclk       (sysclk),
    .cpu_resetn   (cpu_resetn),
    .pc           (pc),
    .op           (op),
    .rt           (rt),
    .rd           (rd),
    .aux          (aux),
    .os           (os),
    .ot           (ot),
    .imm_dpl      (imm_dpl),
    .wreg_e       (wreg_e),
    .wren_e       (wren_e),
    .alu_result_e (alu_result_e),
    .wreg_w       (wreg_w),
    .result_w     (result_w),
    .op_w         (op_w),
    .dm532        (dm532),
    .dm576        (dm576),
    .dm900        (dm900)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Apply one instruction's inputs and let combinational logic settle
  task automatic drive(input logic [5:0] o, input logic [4:0] t, input logic [4:0] d,
                       input logic [10:0] a, input logic [31:0] s, input logic [31:0] tt,
                       input logic [31:0] im, input logic [31:0] p);
    op = o; rt = t; rd = d; aux = a; os = s; ot = tt; imm_dpl = im; pc = p;
    #1;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    cpu_resetn = 1'b0;
    drive(6'd0, 5'd0, 5'd0, 11'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #2;
    checks++;
    if ({op_w, wreg_w, result_w} !== 43'd0) begin
      errors++;
      $display("FAIL reset_regs got op_w=%0d wreg_w=%0d result_w=%h want 0", op_w, wreg_w, result_w);
    end
    tick();
    cpu_resetn = 1'b1;
    #1;
  endtask

  task automatic test_rtype_add();
    drive(6'd0, 5'd0, 5'd9, 11'd0, 32'd7, 32'd5, 32'd0, 32'd0);
    checks++;
    if (alu_result_e !== 32'd12 || wreg_e !== 5'd9) begin
      errors++;
      $display("FAIL add_comb got alu=%h wreg=%0d want 0000000c 9", alu_result_e, wreg_e);
    end
    tick();
    checks++;
    if (result_w !== 32'd12 || wreg_w !== 5'd9 || op_w !== 6'd0) begin
      errors++;
      $display("FAIL add_reg got result_w=%h wreg_w=%0d op_w=%0d want 0000000c 9 0", result_w, wreg_w, op_w);
    end
  endtask

  task automatic test_sra();
    drive(6'd0, 5'd0, 5'd4, (11'd4 << 6) | 11'd18, 32'd0, 32'h8000_0000, 32'd0, 32'd0);
    checks++;
    if (alu_result_e !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra got %h want f8000000", alu_result_e);
    end
  endtask

  task automatic test_alu_misc();
    logic [5:0]  v_op   [10];
    logic [10:0] v_aux  [10];
    logic [31:0] v_os   [10];
    logic [31:0] v_ot   [10];
    logic [31:0] v_imm  [10];
    logic [31:0] v_exp  [10];
    // sub, nor, srl, sll, wrap add, undefined funct, lui, andi, addi, xori
    v_op  = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd3, 6'd4, 6'd1, 6'd6};
    v_aux = '{11'd2, 11'd11, (11'd4 << 6) | 11'd17, (11'd8 << 6) | 11'd16, 11'd0, 11'd3,
              11'd0, 11'd0, 11'd0, 11'd0};
    v_os  = '{32'd5, 32'h0F0F_0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1,
              32'd0, 32'hFFFF_FFFF, 32'd10, 32'h1234_5678};
    v_ot  = '{32'd7, 32'h0000_00F0, 32'h8000_0000, 32'h00AB_CDEF, 32'd1, 32'd1,
              32'd0, 32'd0, 32'd0, 32'd0};
    v_imm = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
              32'h0000_1234, 32'hFFFF_8001, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    v_exp = '{32'hFFFF_FFFE, 32'hF0F0_FF0F, 32'h0800_0000, 32'hABCD_EF00, 32'h0000_0000,
              32'h0000_0000, 32'h1234_0000, 32'h0000_8001, 32'h0000_0007, 32'h1234_A987};
    for (int i = 0; i < 10; i++) begin
      drive(v_op[i], 5'd2, 5'd3, v_aux[i], v_os[i], v_ot[i], v_imm[i], 32'd0);
      checks++;
      if (alu_result_e !== v_exp[i]) begin
        errors++;
        $display("FAIL alu_vec%0d got %h want %h", i, alu_result_e, v_exp[i]);
      end
    end
    checks++;
    if (wreg_e !== 5'd2 || wren_e !== 4'b0000) begin
      errors++;
      $display("FAIL itype_wreg got wreg=%0d wren=%b want 2 0000", wreg_e, wren_e);
    end
  endtask

  task automatic test_store_load();
    drive(6'd24, 5'd0, 5'd0, 11'd0, 32'd0, 32'h0000_0315, 32'd532, 32'd0);
    checks++;
    if (wren_e !== 4'b1111 || alu_result_e !== 32'h315 || wreg_e !== 5'd0) begin
      errors++;
      $display("FAIL sw_comb got wren=%b alu=%h wreg=%0d want 1111 00000315 0", wren_e, alu_result_e, wreg_e);
    end
    tick();
    checks++;
    if (dm532 !== 32'h315) begin
      errors++;
      $display("FAIL sw_dm532 got %h want 00000315", dm532);
    end
    drive(6'd16, 5'd3, 5'd0, 11'd0, 32'd0, 32'd0, 32'd532, 32'd0);
    tick();
    checks++;
    if (result_w !== 32'h315 || wreg_w !== 5'd3 || op_w !== 6'd16) begin
      errors++;
      $display("FAIL lw_back got result_w=%h wreg_w=%0d op_w=%0d want 00000315 3 16", result_w, wreg_w, op_w);
    end
    // Address 532 + 1024 aliases onto the same word
    drive(6'd16, 5'd4, 5'd0, 11'd0, 32'd1024, 32'd0, 32'd532, 32'd0);
    tick();
    checks++;
    if (result_w !== 32'h315) begin
      errors++;
      $display("FAIL lw_alias got %h want 00000315", result_w);
    end
  endtask

  task automatic test_sb_lb();
    drive(6'd24, 5'd0, 5'd0, 11'd0, 32'd576, 32'd0, 32'd0, 32'd0);
    tick();
    drive(6'd28, 5'd0, 5'd0, 11'd0, 32'd576, 32'h1234_56FF, 32'd0, 32'd0);
    checks++;
    if (wren_e !== 4'b0001) begin
      errors++;
      $display("FAIL sb_wren got %b want 0001", wren_e);
    end
    tick();
    drive(6'd20, 5'd5, 5'd0, 11'd0, 32'd576, 32'd0, 32'd0, 32'd0);
    tick();
    checks++;
    if (result_w !== 32'hFFFF_FFFF || dm576 !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL sb_lb got result_w=%h dm576=%h want ffffffff 000000ff", result_w, dm576);
    end
  endtask

  task automatic test_sh_lh();
    drive(6'd24, 5'd0, 5'd0, 11'd0, 32'd900, 32'h1122_3344, 32'd0, 32'd0);
    tick();
    drive(6'd26, 5'd0, 5'd0, 11'd0, 32'd900, 32'hCAFE_8001, 32'd0, 32'd0);
    checks++;
    if (wren_e !== 4'b0011) begin
      errors++;
      $display("FAIL sh_wren got %b want 0011", wren_e);
    end
    tick();
    checks++;
    if (dm900 !== 32'h1122_8001) begin
      errors++;
      $display("FAIL sh_dm900 got %h want 11228001", dm900);
    end
    drive(6'd18, 5'd6, 5'd0, 11'd0, 32'd900, 32'd0, 32'd0, 32'd0);
    checks++;
    if (alu_result_e !== 32'd0 || wreg_e !== 5'd6) begin
      errors++;
      $display("FAIL lh_comb got alu=%h wreg=%0d want 00000000 6", alu_result_e, wreg_e);
    end
    tick();
    checks++;
    if (result_w !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh_sext got %h want ffff8001", result_w);
    end
  endtask

  task automatic test_jal_branch();
    drive(6'd41, 5'd7, 5'd8, 11'd0, 32'd0, 32'd0, 32'd0, 32'd100);
    checks++;
    if (wreg_e !== 5'd31 || alu_result_e !== 32'd101) begin
      errors++;
      $display("FAIL jal_comb got wreg=%0d alu=%0d want 31 101", wreg_e, alu_result_e);
    end
    tick();
    checks++;
    if (result_w !== 32'd101 || wreg_w !== 5'd31 || op_w !== 6'd41) begin
      errors++;
      $display("FAIL jal_reg got result_w=%0d wreg_w=%0d op_w=%0d want 101 31 41", result_w, wreg_w, op_w);
    end
    drive(6'd32, 5'd7, 5'd8, 11'd0, 32'd3, 32'd3, 32'd4, 32'd100);
    checks++;
    if (wreg_e !== 5'd0 || wren_e !== 4'b0000 || alu_result_e !== 32'd0) begin
      errors++;
      $display("FAIL branch got wreg=%0d wren=%b alu=%h want 0 0000 00000000", wreg_e, wren_e, alu_result_e);
    end
  endtask

  task automatic test_async_reset();
    drive(6'd0, 5'd0, 5'd12, 11'd0, 32'd40, 32'd2, 32'd0, 32'd0);
    tick();
    #2;
    cpu_resetn = 1'b0;
    #1;
    checks++;
    if (op_w !== 6'd0 || wreg_w !== 5'd0 || result_w !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got op_w=%0d wreg_w=%0d result_w=%h want 0", op_w, wreg_w, result_w);
    end
    // Store attempted during reset must not land; comb outputs still follow
    drive(6'd24, 5'd0, 5'd0, 11'd0, 32'd532, 32'hDEAD_BEEF, 32'd0, 32'd0);
    checks++;
    if (alu_result_e !== 32'hDEAD_BEEF || wren_e !== 4'b1111) begin
      errors++;
      $display("FAIL reset_comb got alu=%h wren=%b want deadbeef 1111", alu_result_e, wren_e);
    end
    tick();
    checks++;
    if (dm532 !== 32'h315 || dm576 !== 32'h0000_00FF || dm900 !== 32'h1122_8001) begin
      errors++;
      $display("FAIL reset_mem got dm532=%h dm576=%h dm900=%h want 00000315 000000ff 11228001",
               dm532, dm576, dm900);
    end
    drive(6'd63, 5'd0, 5'd0, 11'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    cpu_resetn = 1'b1;
    tick();
    checks++;
    if (op_w !== 6'd63 || result_w !== 32'd0 || wreg_w !== 5'd0) begin
      errors++;
      $display("FAIL halt_after_reset got op_w=%0d result_w=%h wreg_w=%0d want 63 0 0", op_w, result_w, wreg_w);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rtype_add();
    test_sra();
    test_alu_misc();
    test_store_load();
    test_sb_lb();
    test_sh_lh();
    test_jal_branch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
